// File: rtl/iob_fifo_rd_stream_pkg.sv
// Shared constants and types for the FIFO read-side stream adapter:
// output buffer depth, occupancy state encodings and the issue-room helper.
package iob_fifo_rd_stream_pkg;

    // Number of words the output buffer can hold (head + tail).
    localparam int BUF_DEPTH = 2;

    // Occupancy of the output buffer; the encoding equals the word count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // True when buffered words plus the word in flight leave room for one more read.
    function automatic logic room_for_issue(input logic [1:0] cnt, input logic inflight);
        return ({1'b0, cnt} + {2'b00, inflight}) < 3'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/iob_fifo_rd_stream_buf.sv
// Two-entry head/tail register buffer with push, pop and synchronous clear.
// Head is presented to the consumer; a pop while full moves tail into head.
module iob_fifo_rd_stream_buf
    import iob_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [1:0]        cnt_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] head_o
);

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;

    // State and storage registers; a low clock enable freezes everything.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (cke_i) begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Occupancy transitions: next count = count + push - pop, clear wins.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (clr_i) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (push_i) begin
                        head_d  = push_data_i;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push_i && pop_i) begin
                        head_d = push_data_i;
                    end else if (push_i) begin
                        tail_d  = push_data_i;
                        state_d = OCC_TWO;
                    end else if (pop_i) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // The issue logic never lets a push arrive here without a pop.
                    if (pop_i) begin
                        head_d = tail_q;
                        if (push_i) begin
                            tail_d = push_data_i;
                        end else begin
                            state_d = OCC_ONE;
                        end
                    end
                end
                default: state_d = OCC_EMPTY;
            endcase
        end
    end

    assign cnt_o   = state_q;
    assign valid_o = (state_q != OCC_EMPTY);
    assign head_o  = head_q;

endmodule

// File: rtl/iob_fifo_rd_stream.sv
// Read-side adapter turning the async FIFO read port (r_en pulse, 1-cycle
// registered read data, empty flag) into a valid/ready stream with a 2-word
// prefetch buffer. Optional packet framing (len_i / m_last_o) is enabled by
// defining IOB_FIFO_RD_STREAM_LAST_EN.
module iob_fifo_rd_stream
    import iob_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              rst_i,
    output logic              fifo_r_en_o,
    input  logic [DATA_W-1:0] fifo_r_data_i,
    input  logic              fifo_r_empty_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
    ,
    input  logic [LEN_W-1:0]  len_i,
    output logic              m_last_o
`endif
);

    logic       run_q;
    logic       inflight_q, inflight_d;
    logic [1:0] cnt;
    logic       pop;
    logic       issue;
    logic       capture;

    // run_q holds off reads until the first clock edge after reset release.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign pop   = m_valid_o & m_ready_i & cke_i;
    assign issue = run_q & cke_i & ~rst_i & ~fifo_r_empty_i
                 & (room_for_issue(cnt, inflight_q) | pop);
    assign fifo_r_en_o = issue;

    // A word is in flight for exactly one enabled cycle after each read request.
    assign inflight_d = issue;
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            inflight_q <= 1'b0;
        end else if (cke_i) begin
            inflight_q <= inflight_d;
        end
    end

    // A word returning during a flush is dropped on purpose.
    assign capture = inflight_q & ~rst_i;

    iob_fifo_rd_stream_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk_i       (clk_i),
        .arst_n_i    (arst_n_i),
        .cke_i       (cke_i),
        .clr_i       (rst_i),
        .push_i      (capture),
        .push_data_i (fifo_r_data_i),
        .pop_i       (pop),
        .cnt_o       (cnt),
        .valid_o     (m_valid_o),
        .head_o      (m_data_o)
    );

`ifdef IOB_FIFO_RD_STREAM_LAST_EN
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [LEN_W-1:0] len_m1;

    // A zero length behaves as single-beat packets.
    assign len_m1   = (len_i == '0) ? '0 : (len_i - LEN_W'(1));
    assign m_last_o = m_valid_o & (beat_q == len_m1);

    // Beat position within the current packet, wrapping after the last beat.
    always_comb begin
        beat_d = beat_q;
        if (rst_i) begin
            beat_d = '0;
        end else if (pop) begin
            beat_d = m_last_o ? '0 : (beat_q + LEN_W'(1));
        end
    end

    // Beat counter register, frozen when the clock enable is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            beat_q <= '0;
        end else if (cke_i) begin
            beat_q <= beat_d;
        end
    end
`endif

endmodule

// File: tb/tb_iob_fifo_rd_stream.sv
// Self-checking bench for iob_fifo_rd_stream: a behavioural FIFO model feeds
// the DUT, every word leaving the FIFO is queued as expected output, a flush
// discards all read-but-undelivered words, and a monitor compares each
// accepted stream word (and the packet-last flag when enabled).
module tb_iob_fifo_rd_stream;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              cke = 1'b1;
    logic              rst = 1'b0;
    logic              r_en;
    logic [DATA_W-1:0] rdata = '0;
    logic              empty;
    logic              empty_force = 1'b0;
    logic              m_valid;
    logic              ready = 1'b0;
    logic [DATA_W-1:0] m_data;
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
    logic [LEN_W-1:0]  len = 16'd3;
    logic              m_last;
    int                n_last = 0;
    int                beat_idx = 0;
`endif

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int                fifo_cnt = 0;
    int                n_reads = 0;
    int                n_deliv = 0;
    int                n_checks = 0;
    int                n_errors = 0;

    logic              prev_hold = 1'b0;
    logic              prev_flush = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    assign empty = (fifo_cnt == 0) | empty_force;

    iob_fifo_rd_stream #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .cke_i          (cke),
        .rst_i          (rst),
        .fifo_r_en_o    (r_en),
        .fifo_r_data_i  (rdata),
        .fifo_r_empty_i (empty),
        .m_valid_o      (m_valid),
        .m_ready_i      (ready),
        .m_data_o       (m_data)
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
        ,
        .len_i          (len),
        .m_last_o       (m_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        fifo_cnt = fifo_q.size();
    endtask

    task automatic wait_deliv(input int target, input int budget);
        int cyc = 0;
        while (n_deliv < target && cyc < budget) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk("deliv_count", 64'(n_deliv), 64'(target));
    endtask

    // FIFO model: a read pops the next word into the registered read data,
    // which then holds until the next read. A flush forgets undelivered words.
    always @(posedge clk) begin
        logic [DATA_W-1:0] w;
        if (arst_n && cke && rst) begin
            exp_q.delete();
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
            beat_idx = 0;
`endif
        end
        if (r_en && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            fifo_cnt = fifo_q.size();
            rdata <= w;
            exp_q.push_back(w);
            n_reads++;
        end
    end

    // Monitor: compares every accepted word and checks protocol rules.
    always @(negedge clk) begin
        if (arst_n) begin
            if (empty) chk("rd_when_empty", 64'(r_en), 64'd0);
            if (prev_hold && !prev_flush) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_data", 64'(m_data), 64'(prev_data));
            end
            if (m_valid && ready && cke) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL stream_extra: got %0h expected no word", m_data);
                end else begin
                    chk("stream_data", 64'(m_data), 64'(exp_q.pop_front()));
                end
`ifdef IOB_FIFO_RD_STREAM_LAST_EN
                begin
                    int len_eff;
                    len_eff = (len == 0) ? 1 : int'(len);
                    chk("m_last", 64'(m_last), 64'((beat_idx % len_eff) == (len_eff - 1)));
                    if (m_last) n_last++;
                    beat_idx++;
                end
`endif
                n_deliv++;
            end
            prev_hold  = m_valid & ~ready;
            prev_data  = m_data;
            prev_flush = rst & cke;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATA_W-1:0] w0;
        logic [DATA_W-1:0] wv[4];
        int base;
        int sent;
        int cyc;

        // 1: reset state, first read one cycle after release, A,B,C back to back
        push_word(32'hA000_000A);
        push_word(32'hB000_000B);
        push_word(32'hC000_000C);
        ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_en", 64'(r_en), 64'd0);
        chk("reset_valid", 64'(m_valid), 64'd0);
        chk("reset_data", 64'(m_data), 64'd0);
        #2 arst_n = 1'b1;
        #1 chk("release_rd_en", 64'(r_en), 64'd0);
        @(posedge clk); #1;
        chk("first_rd_en", 64'(r_en), 64'd1);
        @(posedge clk); #1;
        chk("latency_valid0", 64'(m_valid), 64'd0);
        @(posedge clk); #1;
        chk("word_a_valid", 64'(m_valid), 64'd1);
        chk("word_a", 64'(m_data), 64'h A000_000A);
        @(posedge clk); #1;
        chk("word_b", 64'(m_data), 64'hB000_000B);
        @(posedge clk); #1;
        chk("word_c", 64'(m_data), 64'hC000_000C);
        @(posedge clk); #1;
        chk("drained_valid", 64'(m_valid), 64'd0);

        // 2: backpressure with 8 words queued -> only 2 reads, head stable
        ready = 1'b0;
        base = n_reads;
        w0 = $urandom;
        push_word(w0);
        for (int i = 1; i < 8; i++) push_word($urandom);
        repeat (6) @(posedge clk);
        #1;
        chk("bp_reads", 64'(n_reads - base), 64'd2);
        chk("bp_valid", 64'(m_valid), 64'd1);
        chk("bp_head", 64'(m_data), 64'(w0));
        ready = 1'b1;
        wait_deliv(n_deliv + 8, 100);
        repeat (3) @(posedge clk);
        #1;

        // 4: flush while one word is buffered and the next is in flight
        ready = 1'b0;
        base = n_reads;
        for (int i = 0; i < 4; i++) begin
            wv[i] = $urandom;
            push_word(wv[i]);
        end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("flush_valid", 64'(m_valid), 64'd0);
        chk("flush_reads", 64'(n_reads - base), 64'd2);
        base = n_deliv;
        @(posedge clk);
        @(posedge clk); #1;
        chk("after_flush_head", 64'(m_data), 64'(wv[2]));
        ready = 1'b1;
        wait_deliv(base + 2, 50);
        repeat (3) @(posedge clk);
        #1;

        // 5: clock enable low between read request and capture
        w0 = $urandom;
        push_word(w0);
        cyc = 0;
        while (!r_en && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("cke_rd_seen", 64'(r_en), 64'd1);
        @(posedge clk); #1;
        cke = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("cke_frozen_valid", 64'(m_valid), 64'd0);
        end
        cke = 1'b1;
        @(posedge clk); #1;
        chk("cke_capture_valid", 64'(m_valid), 64'd1);
        chk("cke_capture_data", 64'(m_data), 64'(w0));
        wait_deliv(n_deliv + 1, 20);

        // 3: random FIFO availability and alternating ready for 1000 words
        base = n_deliv;
        sent = 0;
        cyc = 0;
        while (n_deliv < base + 1000 && cyc < 12000) begin
            @(posedge clk); #1;
            ready = ~ready;
            empty_force = ($urandom_range(0, 1) == 1);
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                push_word($urandom);
                sent++;
            end
            cyc++;
        end
        empty_force = 1'b0;
        ready = 1'b1;
        wait_deliv(base + 1000, 200);
        chk("random_fifo_left", 64'(fifo_cnt), 64'd0);

`ifdef IOB_FIFO_RD_STREAM_LAST_EN
        // 6: packet framing, len=3 over 7 words then len=0
        @(posedge clk); #1;
        rst = 1'b1;
        len = 16'd3;
        @(posedge clk); #1;
        rst = 1'b0;
        n_last = 0;
        base = n_deliv;
        for (int i = 0; i < 7; i++) push_word($urandom);
        wait_deliv(base + 7, 50);
        chk("last_count_len3", 64'(n_last), 64'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        len = 16'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_last = 0;
        base = n_deliv;
        for (int i = 0; i < 3; i++) push_word($urandom);
        wait_deliv(base + 3, 50);
        chk("last_count_len0", 64'(n_last), 64'd3);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
